emitter_uart_stream: RTL and testbench

- Parametrised successor to the fixed 8N1 byte emitter on the corescore GateMate top.
- Accepts an AXI-stream byte/word stream and buffers it in an internal FIFO, so the core is not stalled on every character.
- Serialises words onto a UART TX line with configurable data width, parity and stop bits.
- Reports FIFO level, busy status and end-of-packet completion, taken from tlast.

---
 rtl/emitter_uart_stream.sv | 197 +++++++++++++++++++
 tb/tb_emitter_uart_stream.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/emitter_uart_stream.sv
// Buffered AXI-stream to UART transmitter: FIFO of {tlast, data} words feeding
// a start/data/parity/stop serialiser with a per-bit down-counting baud timer.
module emitter_uart_stream #(
  parameter int CLK_FREQ_HZ = 16_000_000,
  parameter int BAUD_RATE   = 57600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DATA_BITS-1:0]          i_tdata,
  input  logic                          i_tlast,
  input  logic                          i_tvalid,
  output logic                          o_tready,
  output logic                          o_uart_tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level,
  output logic                          o_pkt_done
);

  localparam int DIV = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);
  localparam int BW  = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CW-1:0] CNT_LOAD = CW'(DIV - 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

  // state    | meaning
  // S_IDLE   | line high; pops the next word when the FIFO holds one
  // S_START  | start bit (low) for one bit period
  // S_DATA   | payload bits, LSB first
  // S_PARITY | optional parity bit
  // S_STOP   | stop bit(s) high; returns to idle and flags end of packet
  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [DATA_BITS:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wptr_q, rptr_q;
  logic [AW:0]          level_q, level_d;
  logic                 push, pop, full;
  logic [DATA_BITS:0]   rd_word;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 last_q, last_d;
  logic                 done_q, done_d;
  logic                 tx_q, tx_d;
  logic                 tick;

  assign full     = (level_q == FULL_LVL);
  assign o_tready = i_rst_n && !full;
  assign push     = i_tvalid && o_tready;
  assign pop      = (state_q == S_IDLE) && (level_q != '0);
  assign level_d  = level_q + (AW + 1)'(push) - (AW + 1)'(pop);
  assign rd_word  = mem_q[rptr_q];
  assign tick     = (cnt_q == '0);

  always_ff @(posedge i_clk) begin
    if (push) begin
      mem_q[wptr_q] <= {i_tlast, i_tdata};
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    stop_d  = stop_q;
    shift_d = shift_q;
    par_d   = par_q;
    last_d  = last_q;
    done_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (pop) begin
          {last_d, shift_d} = rd_word;
          par_d   = (PARITY == 1) ? ~(^rd_word[DATA_BITS-1:0]) : ^rd_word[DATA_BITS-1:0];
          cnt_d   = CNT_LOAD;
          bit_d   = '0;
          stop_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (tick) begin
          cnt_d   = CNT_LOAD;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (tick) begin
          cnt_d   = CNT_LOAD;
          shift_d = shift_q >> 1;
          if (bit_q == LAST_BIT) begin
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PARITY: begin
        if (tick) begin
          cnt_d   = CNT_LOAD;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        if (tick) begin
          if ((STOP_BITS == 1) || stop_q) begin
            cnt_d   = '0;
            done_d  = last_q;
            state_d = S_IDLE;
          end else begin
            cnt_d  = CNT_LOAD;
            stop_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // The line level is registered from the next-state view so it never glitches.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      shift_q <= '0;
      par_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      last_q  <= last_d;
      done_q  <= done_d;
      tx_q    <= tx_d;
    end
  end

  assign o_uart_tx    = tx_q;
  assign o_pkt_done   = done_q;
  assign o_fifo_level = level_q;
  assign o_busy       = (state_q != S_IDLE) || (level_q != '0);

endmodule

// File: tb/tb_emitter_uart_stream.sv
// Testbench for emitter_uart_stream: four configurations (8N1, 8E2, 8O1, 7N1) at DIV=10,
// each frame compared cycle by cycle against a bit list expanded from the word.
module tb_emitter_uart_stream;
  localparam int DIV   = 10;
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  int         sel;
  logic [8:0] t_data;
  logic       t_last, t_valid;
  int         errors = 0;
  int         checks = 0;

  logic a_tvalid, a_tready, a_tx, a_busy, a_done;
  logic b_tvalid, b_tready, b_tx, b_busy, b_done;
  logic c_tvalid, c_tready, c_tx, c_busy, c_done;
  logic d_tvalid, d_tready, d_tx, d_busy, d_done;
  logic [4:0] a_level, b_level, c_level, d_level;

  assign a_tvalid = t_valid && (sel == 0);
  assign b_tvalid = t_valid && (sel == 1);
  assign c_tvalid = t_valid && (sel == 2);
  assign d_tvalid = t_valid && (sel == 3);

  emitter_uart_stream #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(t_data[7:0]), .i_tlast(t_last),
    .i_tvalid(a_tvalid), .o_tready(a_tready), .o_uart_tx(a_tx), .o_busy(a_busy),
    .o_fifo_level(a_level), .o_pkt_done(a_done));

  emitter_uart_stream #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                        .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(16)) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(t_data[7:0]), .i_tlast(t_last),
    .i_tvalid(b_tvalid), .o_tready(b_tready), .o_uart_tx(b_tx), .o_busy(b_busy),
    .o_fifo_level(b_level), .o_pkt_done(b_done));

  emitter_uart_stream #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(8),
                        .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(16)) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(t_data[7:0]), .i_tlast(t_last),
    .i_tvalid(c_tvalid), .o_tready(c_tready), .o_uart_tx(c_tx), .o_busy(c_busy),
    .o_fifo_level(c_level), .o_pkt_done(c_done));

  emitter_uart_stream #(.CLK_FREQ_HZ(1_000_000), .BAUD_RATE(100_000), .DATA_BITS(7),
                        .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(16)) u_d (
    .i_clk(clk), .i_rst_n(rst_n), .i_tdata(t_data[6:0]), .i_tlast(t_last),
    .i_tvalid(d_tvalid), .o_tready(d_tready), .o_uart_tx(d_tx), .o_busy(d_busy),
    .o_fifo_level(d_level), .o_pkt_done(d_done));

  function automatic logic f_tx();
    case (sel) 0: return a_tx; 1: return b_tx; 2: return c_tx; default: return d_tx; endcase
  endfunction
  function automatic logic f_busy();
    case (sel) 0: return a_busy; 1: return b_busy; 2: return c_busy; default: return d_busy; endcase
  endfunction
  function automatic logic f_done();
    case (sel) 0: return a_done; 1: return b_done; 2: return c_done; default: return d_done; endcase
  endfunction
  function automatic logic f_rdy();
    case (sel) 0: return a_tready; 1: return b_tready; 2: return c_tready; default: return d_tready; endcase
  endfunction
  function automatic logic [4:0] f_level();
    case (sel) 0: return a_level; 1: return b_level; 2: return c_level; default: return d_level; endcase
  endfunction

  // Offer one word from a falling edge; returns on the falling edge after acceptance.
  task automatic push(input logic [8:0] d, input logic l);
    int g = 0;
    t_data = d; t_last = l; t_valid = 1'b1;
    while (f_rdy() !== 1'b1 && g < LIMIT) begin @(negedge clk); g++; end
    checks++;
    if (f_rdy() !== 1'b1) begin
      errors++;
      $display("FAIL push_ready: tready=%b after %0d cycles, expected 1", f_rdy(), g);
    end
    @(negedge clk);
    t_valid = 1'b0; t_last = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin @(negedge clk); n++; end while (f_tx() !== 1'b0 && n < 3000);
    checks++;
    if (f_tx() !== 1'b0) begin
      errors++;
      $display("FAIL start_timeout: tx=%b after %0d cycles, expected 0", f_tx(), n);
    end
  endtask

  // Called on the first low cycle; ends on the idle cycle following the last stop bit.
  task automatic check_frame(input logic [8:0] d, input int nbits, input int par, input int nstop,
                             input logic last_exp, input logic busy_exp, input string nm);
    bit   bits[$];
    bit   p, ok;
    logic bad_tx, bad_done, bad_busy;
    p = 1'b0;
    bits.push_back(1'b0);
    for (int i = 0; i < nbits; i++) begin bits.push_back(d[i]); p ^= d[i]; end
    if (par == 1) bits.push_back(~p);
    else if (par == 2) bits.push_back(p);
    for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    for (int b = 0; b < bits.size(); b++) begin
      ok = 1'b1; bad_tx = 1'bx; bad_done = 1'bx; bad_busy = 1'bx;
      for (int c = 0; c < DIV; c++) begin
        if (b != 0 || c != 0) @(negedge clk);
        if ((f_tx() !== bits[b] || f_done() !== 1'b0 || f_busy() !== 1'b1) && ok) begin
          ok = 1'b0; bad_tx = f_tx(); bad_done = f_done(); bad_busy = f_busy();
        end
      end
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s bit%0d: got tx=%b done=%b busy=%b, expected tx=%b done=0 busy=1",
                 nm, b, bad_tx, bad_done, bad_busy, bits[b]);
      end
    end
    @(negedge clk);
    checks++;
    if (f_tx() !== 1'b1 || f_done() !== last_exp || f_busy() !== busy_exp) begin
      errors++;
      $display("FAIL %s after_stop: got tx=%b done=%b busy=%b, expected tx=1 done=%b busy=%b",
               nm, f_tx(), f_done(), f_busy(), last_exp, busy_exp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      checks++;
      if (f_tx() !== 1'b1 || f_rdy() !== 1'b0 || f_busy() !== 1'b0 ||
          f_level() !== 5'd0 || f_done() !== 1'b0) begin
        errors++;
        $display("FAIL reset_dut%0d: tx=%b rdy=%b busy=%b level=%0d done=%b, expected 1 0 0 0 0",
                 s, f_tx(), f_rdy(), f_busy(), f_level(), f_done());
      end
    end
    sel = 0;
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (f_rdy() !== 1'b1 || f_busy() !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: rdy=%b busy=%b, expected 1 0", f_rdy(), f_busy());
    end
  endtask

  task automatic test_basic();
    int n;
    sel = 0;
    push(9'h055, 1'b0);
    checks++;
    if (f_level() !== 5'd1 || f_tx() !== 1'b1 || f_busy() !== 1'b1) begin
      errors++;
      $display("FAIL basic_buffered: level=%0d tx=%b busy=%b, expected 1 1 1", f_level(), f_tx(), f_busy());
    end
    wait_start(n);
    checks++;
    if (n !== 1 || f_level() !== 5'd0) begin
      errors++;
      $display("FAIL basic_start: start after %0d cycles level=%0d, expected 1 and 0", n, f_level());
    end
    check_frame(9'h055, 8, 0, 1, 1'b0, 1'b0, "basic_8n1");
  endtask

  task automatic test_formats();
    int n, nb, par, ns;
    logic [8:0] w;
    for (int s = 1; s < 4; s++) begin
      sel = s;
      nb  = (s == 3) ? 7 : 8;
      par = (s == 1) ? 2 : (s == 2) ? 1 : 0;
      ns  = (s == 1) ? 2 : 1;
      for (int k = 0; k < 4; k++) begin
        if (k == 0) w = (s == 3) ? 9'h041 : 9'h007;
        else w = 9'($urandom_range(0, (1 << nb) - 1));
        push(w, 1'b0);
        wait_start(n);
        checks++;
        if (n !== 1) begin
          errors++;
          $display("FAIL fmt%0d_latency: start after %0d cycles, expected 1", s, n);
        end
        check_frame(w, nb, par, ns, 1'b0, 1'b0, $sformatf("fmt%0d_w%0d", s, k));
      end
    end
    sel = 0;
  endtask

  task automatic test_backpressure();
    logic [8:0] w[20];
    sel = 0;
    for (int i = 0; i < 20; i++) w[i] = 9'($urandom_range(0, 255));
    fork
      begin
        int k, g;
        logic rdy, stalled, resumed;
        k = 0; g = 0; stalled = 1'b0; resumed = 1'b0;
        t_data = w[0]; t_last = 1'b0; t_valid = 1'b1;
        while (k < 20 && g < 5000) begin
          rdy = f_rdy();
          @(negedge clk);
          g++;
          if (rdy) begin
            k++;
            if (k < 20) t_data = w[k]; else t_valid = 1'b0;
          end
          if (!stalled && k == 17 && f_rdy() == 1'b0) begin
            stalled = 1'b1;
            checks++;
            if (f_level() !== 5'd16) begin
              errors++;
              $display("FAIL bp_full_level: level=%0d, expected 16", f_level());
            end
          end else if (stalled && !resumed && f_rdy() == 1'b1) begin
            resumed = 1'b1;
            checks++;
            if (f_level() !== 5'd15 || k !== 17) begin
              errors++;
              $display("FAIL bp_resume: level=%0d accepted=%0d, expected 15 and 17", f_level(), k);
            end
          end
        end
        t_valid = 1'b0;
        checks++;
        if (!stalled || !resumed || k !== 20) begin
          errors++;
          $display("FAIL bp_flow: stalled=%b resumed=%b accepted=%0d, expected 1 1 20", stalled, resumed, k);
        end
      end
      begin
        int n;
        for (int i = 0; i < 20; i++) begin
          wait_start(n);
          if (i > 0) begin
            checks++;
            if (n !== 1) begin
              errors++;
              $display("FAIL bp_gap%0d: start after %0d cycles, expected 1", i, n);
            end
          end
          check_frame(w[i], 8, 0, 1, 1'b0, (i < 19), $sformatf("bp_w%0d", i));
        end
      end
    join
  endtask

  task automatic test_packet();
    logic [8:0] w[3];
    sel = 0;
    for (int i = 0; i < 3; i++) w[i] = 9'($urandom_range(0, 255));
    fork
      for (int i = 0; i < 3; i++) push(w[i], (i == 2));
      begin
        int n;
        for (int i = 0; i < 3; i++) begin
          wait_start(n);
          check_frame(w[i], 8, 0, 1, (i == 2), (i < 2), $sformatf("pkt_w%0d", i));
        end
      end
    join
    @(negedge clk);
    checks++;
    if (f_done() !== 1'b0) begin
      errors++;
      $display("FAIL pkt_pulse_width: done=%b, expected 0", f_done());
    end
  endtask

  task automatic test_reset_mid();
    logic [8:0] w0;
    logic       ok;
    sel = 0;
    w0 = 9'($urandom_range(0, 255)) & 9'h0F7;
    fork
      begin
        push(w0, 1'b0);
        for (int i = 0; i < 5; i++) push(9'($urandom_range(0, 255)), 1'b1);
      end
      begin
        int n;
        wait_start(n);
        repeat (44) @(negedge clk);
        checks++;
        if (f_tx() !== 1'b0 || f_level() !== 5'd5) begin
          errors++;
          $display("FAIL mid_before: tx=%b level=%0d, expected 0 and 5", f_tx(), f_level());
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (f_tx() !== 1'b1 || f_level() !== 5'd0 || f_busy() !== 1'b0 ||
            f_done() !== 1'b0 || f_rdy() !== 1'b0) begin
          errors++;
          $display("FAIL mid_reset: tx=%b level=%0d busy=%b done=%b rdy=%b, expected 1 0 0 0 0",
                   f_tx(), f_level(), f_busy(), f_done(), f_rdy());
        end
      end
    join
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (f_tx() !== 1'b1 || f_done() !== 1'b0 || f_level() !== 5'd0) ok = 1'b0;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL mid_after: tx=%b done=%b level=%0d, expected line idle 1 0 0 throughout",
               f_tx(), f_done(), f_level());
    end
  endtask

  initial begin
    rst_n = 1'b0; sel = 0; t_data = '0; t_last = 1'b0; t_valid = 1'b0;
    test_reset();
    test_basic();
    test_formats();
    test_backpressure();
    test_packet();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
